icache_direct: RTL and testbench
================================

# icache_direct

Direct-mapped instruction cache between the fetch stage and the 128-bit line-wide instruction memory. Serves 32-bit instruction words on hit with one-cycle latency. On miss, presents a line-aligned address to the memory, waits a fixed memory latency, captures the 16-byte line, and returns the requested word. The fetch stage sees only `instr`, `instr_valid` and `stall`.

## Interface
- `NUM_LINES`, 8: number of cache lines; power of two, at least 2; index width `IDX = log2(NUM_LINES)`.
- `MEM_LATENCY`, 6: cycles `mem_addr` is held before `mem_line` is sampled; at least 1.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `cpu_req` in 1: fetch request valid.
- `cpu_addr` in 32: byte address of the requested instruction; bits [1:0] ignored.
- `instr` out 32: returned instruction word.
- `instr_valid` out 1: `instr` valid this cycle; single-cycle pulse per request.
- `stall` out 1: miss in progress; fetch must not issue.
- `mem_addr` out 32: line-aligned address to memory; bits [3:0] always 0.
- `mem_line` in 128: line from memory; byte n of line at bits [8n+7:8n].
- `hit_count` out 32, `miss_count` out 32: present only with `ICACHE_STATS_EN`.

## Operation
- Address split:
  - offset = [3:0], with word select [3:2];
  - index = [4+IDX-1:4];
  - tag = [31:4+IDX].
- Storage per line: valid bit, tag, and 128-bit data. Word k of a line is data[32k+31:32k].
- FSM states: `IDLE`, `MISS_WAIT`, `FILL`.
- `IDLE`, `cpu_req`=1, hit (valid and tag match):
  - next cycle `instr` = selected word and `instr_valid`=1;
  - stay in `IDLE`;
  - back-to-back hits sustain one word per cycle.
- `IDLE`, `cpu_req`=1, miss:
  - latch the request address;
  - `mem_addr` <= {addr[31:4], 4'b0};
  - wait counter <= 0;
  - `stall` <= 1;
  - go to `MISS_WAIT`.
- `MISS_WAIT`:
  - counter increments each cycle;
  - when counter == `MEM_LATENCY-1`, write `mem_line` into the indexed line, set valid, write tag, and go to `FILL`.
- `FILL`:
  - `instr` = latched word from the newly written line;
  - `instr_valid`=1;
  - `stall` <= 0;
  - go to `IDLE`.
- `cpu_req` and `cpu_addr` are ignored while `stall`=1. The latched address is served, and no request is queued.
- `mem_addr` holds its last value in `IDLE`.
- Replacement: always overwrites the indexed line (direct-mapped; no write path from the CPU).
- `cpu_req`=0 in `IDLE`: `instr_valid`=0 next cycle; `instr` holds its last value.

## Timing
- Reset values:
  - `instr`=0, `instr_valid`=0, `stall`=0, `mem_addr`=0;
  - all valid bits 0;
  - state `IDLE`, counter 0;
  - stat counters 0.
  - Data/tag arrays need not be reset.
- Hit latency: 1 cycle from request edge to `instr_valid`.
- Miss latency: `MEM_LATENCY`+2 cycles from request edge to `instr_valid`. `stall` is high for `MEM_LATENCY`+1 cycles.
- `mem_addr` is stable for the entire `MISS_WAIT` interval.
- Reset during `MISS_WAIT` or `FILL`:
  - aborts the fill;
  - no line is written;
  - outputs take reset values on the next edge.
- Counter width: `$clog2(MEM_LATENCY)+1`; no wrap occurs before the terminal compare.

## Configuration
- `ICACHE_STATS_EN` defined:
  - `hit_count` increments on each hit request;
  - `miss_count` increments on each miss request (at entry to `MISS_WAIT`);
  - both saturate at 0xFFFFFFFF and are cleared by reset.
- Not defined: ports and counters are absent; all other behaviour is identical.

## Test plan
Bench memory model returns the line at `mem_addr` with byte[i] = i[7:0], valid after `MEM_LATENCY` cycles. Defaults apply throughout.

- Reset, then request 0x00 -> `mem_addr`=0x00, `stall` high 7 cycles, `instr`=0x03020100 with `instr_valid` on cycle 8.
- Then request 0x04, then 0x0C on consecutive cycles -> two hits, `instr`=0x07060504 then 0x0F0E0D0C, `stall` stays 0.
- Conflict case:
  - request 0x80 (index 0, tag 1) -> miss, `instr`=0x83828180;
  - then request 0x00 -> miss again, `instr`=0x03020100.
- Change `cpu_addr` to 0x40 mid-miss for 0x10 -> `mem_addr` stays 0x10, `instr`=0x13121110; a subsequent 0x40 request misses.
- Drive `rst_n`=0 on cycle 3 of a miss -> `stall`=0 and `instr_valid`=0 next cycle; re-request 0x00 misses.
- With `ICACHE_STATS_EN`, run the first two scenarios -> `hit_count`=2, `miss_count`=1.

Source files
------------

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache: one-cycle hits, fixed-latency line fill on miss.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
module icache_direct #(
  parameter int unsigned NUM_LINES   = 8,
  parameter int unsigned MEM_LATENCY = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cpu_req,
  input  logic [31:0]  cpu_addr,
  output logic [31:0]  instr,
  output logic         instr_valid,
  output logic         stall,
  output logic [31:0]  mem_addr,
  input  logic [127:0] mem_line
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int unsigned IDX   = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = 32 - 4 - IDX;
  localparam int unsigned CNT_W = $clog2(MEM_LATENCY) + 1;

  typedef enum logic [1:0] {
    IDLE,
    MISS_WAIT,
    FILL
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [127:0]         r_data [NUM_LINES];

  logic [31:2]          r_req_addr;
  logic [CNT_W-1:0]     r_cnt;

  logic [IDX-1:0]       w_idx;
  logic [TAG_W-1:0]     w_tag;
  logic                 w_hit;
  logic [31:0]          w_hit_word;
  logic [IDX-1:0]       w_req_idx;
  logic [TAG_W-1:0]     w_req_tag;
  logic [31:0]          w_fill_word;
  logic                 w_cnt_done;
  logic                 w_unused;

  // Request decode and lookup against the indexed line
  assign w_idx      = cpu_addr[4 +: IDX];
  assign w_tag      = cpu_addr[31 -: TAG_W];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_hit_word = r_data[w_idx][{cpu_addr[3:2], 5'b0} +: 32];

  // Latched miss address decode
  assign w_req_idx   = r_req_addr[4 +: IDX];
  assign w_req_tag   = r_req_addr[31 -: TAG_W];
  assign w_fill_word = r_data[w_req_idx][{r_req_addr[3:2], 5'b0} +: 32];
  assign w_cnt_done  = (r_cnt == CNT_W'(MEM_LATENCY - 1));

  // Byte-within-word bits carry no meaning for instruction fetch
  assign w_unused = ^cpu_addr[1:0];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (cpu_req && !w_hit) w_state_nxt = MISS_WAIT;
      MISS_WAIT: if (w_cnt_done) w_state_nxt = FILL;
      FILL:      w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // Registered outputs, miss bookkeeping and valid bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr       <= '0;
      instr_valid <= 1'b0;
      stall       <= 1'b0;
      mem_addr    <= '0;
      r_valid     <= '0;
      r_cnt       <= '0;
      r_req_addr  <= '0;
    end else begin
      instr_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cpu_req) begin
            if (w_hit) begin
              instr       <= w_hit_word;
              instr_valid <= 1'b1;
            end else begin
              r_req_addr <= cpu_addr[31:2];
              mem_addr   <= {cpu_addr[31:4], 4'b0};
              r_cnt      <= '0;
              stall      <= 1'b1;
            end
          end
        end
        MISS_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_cnt_done) r_valid[w_req_idx] <= 1'b1;
        end
        FILL: begin
          instr       <= w_fill_word;
          instr_valid <= 1'b1;
          stall       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Tag/data arrays: written once per fill when the memory line is sampled
  always_ff @(posedge clk) begin
    if (rst_n && (r_state == MISS_WAIT) && w_cnt_done) begin
      r_tag[w_req_idx]  <= w_req_tag;
      r_data[w_req_idx] <= mem_line;
    end
  end

`ifdef ICACHE_STATS_EN
  // Saturating hit/miss counters, updated when a request is accepted in IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if ((r_state == IDLE) && cpu_req) begin
      if (w_hit) begin
        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios plus randomized traffic
// compared every cycle against a behavioural cache model.
module tb_icache_direct;

  localparam int unsigned NUM_LINES   = 8;
  localparam int unsigned MEM_LATENCY = 6;

  logic         clk;
  logic         rst_n;
  logic         cpu_req;
  logic [31:0]  cpu_addr;
  logic [31:0]  instr;
  logic         instr_valid;
  logic         stall;
  logic [31:0]  mem_addr;
  logic [127:0] mem_line;
`ifdef ICACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  icache_direct #(
    .NUM_LINES  (NUM_LINES),
    .MEM_LATENCY(MEM_LATENCY)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .instr      (instr),
    .instr_valid(instr_valid),
    .stall      (stall),
    .mem_addr   (mem_addr),
    .mem_line   (mem_line)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return {a[31:4], 4'b0};
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:2], 2'b0};
    return {8'(b + 32'd3), 8'(b + 32'd2), 8'(b + 32'd1), 8'(b)};
  endfunction

  function automatic logic [127:0] pattern(input logic [31:0] la);
    logic [127:0] l;
    for (int n = 0; n < 16; n++) l[8*n +: 8] = 8'(la + 32'(n));
    return l;
  endfunction

  // Memory: line content is only correct once mem_addr has been held MEM_LATENCY cycles
  int mem_age;
  always @(posedge clk) mem_age <= stall ? mem_age + 1 : 0;

  always_comb begin
    mem_line = {4{32'hDEAD_BEEF}};
    if (stall && (mem_age >= int'(MEM_LATENCY) - 1)) mem_line = pattern(mem_addr);
  end

  // Behavioural model: which lines are resident and how many cycles a miss still owes
  bit          m_valid [NUM_LINES];
  logic [31:0] m_line  [NUM_LINES];
  int          rem;
  logic [31:0] p_addr;
  logic [31:0] exp_instr, exp_mem_addr, m_hits, m_misses;
  logic        exp_valid, exp_stall;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 4) % NUM_LINES);
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      exp_instr = '0; exp_valid = 1'b0; exp_stall = 1'b0; exp_mem_addr = '0;
      for (int i = 0; i < NUM_LINES; i++) m_valid[i] = 1'b0;
      rem = 0; m_hits = '0; m_misses = '0;
    end else if (rem > 0) begin
      exp_valid = 1'b0;
      rem--;
      if (rem == 0) begin
        m_valid[idx_of(p_addr)] = 1'b1;
        m_line[idx_of(p_addr)]  = line_of(p_addr);
        exp_valid = 1'b1;
        exp_instr = word_of(p_addr);
        exp_stall = 1'b0;
      end
    end else begin
      exp_valid = 1'b0;
      if (cpu_req) begin
        if (m_valid[idx_of(cpu_addr)] && m_line[idx_of(cpu_addr)] == line_of(cpu_addr)) begin
          exp_valid = 1'b1;
          exp_instr = word_of(cpu_addr);
          if (m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 32'd1;
        end else begin
          p_addr       = cpu_addr;
          rem          = int'(MEM_LATENCY) + 1;
          exp_stall    = 1'b1;
          exp_mem_addr = line_of(cpu_addr);
          if (m_misses != 32'hFFFF_FFFF) m_misses = m_misses + 32'd1;
        end
      end
    end
  endtask

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("instr_valid", 32'(instr_valid), 32'(exp_valid));
      check("instr", instr, exp_instr);
      check("stall", 32'(stall), 32'(exp_stall));
      check("mem_addr", mem_addr, exp_mem_addr);
`ifdef ICACHE_STATS_EN
      check("hit_count", hit_count, m_hits);
      check("miss_count", miss_count, m_misses);
`endif
    end
  end

  // One clock: drive inputs, let the edge happen, advance the model, settle
  task automatic cycle(input logic rst, input logic req, input logic [31:0] a);
    rst_n    = rst;
    cpu_req  = req;
    cpu_addr = a;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wait_valid(input logic req, input logic [31:0] a);
    for (int i = 0; i < 20 && !instr_valid; i++) cycle(1'b1, req, a);
    check("fill_timeout", 32'(instr_valid), 32'd1);
  endtask

  int stall_cycles;

  initial begin
    rst_n = 1'b0; cpu_req = 1'b0; cpu_addr = '0;
    #2;
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    chk_en = 1'b1;
    check("rst_instr", instr, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);

    // Cold miss on 0x00
    cycle(1'b1, 1'b1, 32'h0000_0000);
    check("miss0_mem_addr", mem_addr, 32'h0);
    stall_cycles = int'(stall);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      stall_cycles += int'(stall);
    end
    check("miss0_stall_len", 32'(stall_cycles), 32'd7);
    check("miss0_valid_late", 32'(instr_valid), 32'd0);
    cycle(1'b1, 1'b0, 32'h0);
    check("miss0_valid", 32'(instr_valid), 32'd1);
    check("miss0_instr", instr, 32'h0302_0100);
    check("miss0_stall_drop", 32'(stall), 32'd0);

    // Back-to-back hits in the same line
    cycle(1'b1, 1'b1, 32'h0000_0004);
    check("hit4_valid", 32'(instr_valid), 32'd1);
    check("hit4_instr", instr, 32'h0706_0504);
    cycle(1'b1, 1'b1, 32'h0000_000C);
    check("hitC_instr", instr, 32'h0F0E_0D0C);
    check("hitC_stall", 32'(stall), 32'd0);
`ifdef ICACHE_STATS_EN
    check("stats_hits", hit_count, 32'd2);
    check("stats_misses", miss_count, 32'd1);
`endif
    cycle(1'b1, 1'b0, 32'h0);
    check("idle_valid", 32'(instr_valid), 32'd0);
    check("idle_instr_hold", instr, 32'h0F0E_0D0C);

    // Conflict eviction in index 0
    cycle(1'b1, 1'b1, 32'h0000_0080);
    check("conf_mem_addr", mem_addr, 32'h80);
    wait_valid(1'b0, 32'h0);
    check("conf_instr", instr, 32'h8382_8180);
    cycle(1'b1, 1'b1, 32'h0000_0000);
    check("remiss_stall", 32'(stall), 32'd1);
    wait_valid(1'b0, 32'h0);
    check("remiss_instr", instr, 32'h0302_0100);

    // Address change during a miss is ignored
    cycle(1'b1, 1'b1, 32'h0000_0010);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 32'h0000_0040);
    check("midmiss_mem_addr", mem_addr, 32'h10);
    wait_valid(1'b1, 32'h0000_0040);
    check("midmiss_instr", instr, 32'h1312_1110);
    cycle(1'b1, 1'b1, 32'h0000_0040);
    check("miss40_stall", 32'(stall), 32'd1);
    wait_valid(1'b0, 32'h0);
    check("miss40_instr", instr, 32'h4342_4140);

    // Reset in the middle of a miss
    cycle(1'b1, 1'b1, 32'h0000_0100);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    check("abort_stall", 32'(stall), 32'd0);
    check("abort_valid", 32'(instr_valid), 32'd0);
    cycle(1'b1, 1'b1, 32'h0000_0000);
    check("post_rst_miss", 32'(stall), 32'd1);
    wait_valid(1'b0, 32'h0);
    check("post_rst_instr", instr, 32'h0302_0100);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] a;
      a = $urandom & 32'h0000_03FC;
      if ($urandom_range(0, 15) == 0) a = a | ($urandom & 32'hFFFF_FC00);
      cycle(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0), a);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
